// File: rtl/compare_4_32_stream.sv
// compare_4_32_stream: collects four operands and reports max/min values, masks and lowest indices
module compare_4_32_stream #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       lrg_mask,
    output logic [3:0]       sml_mask,
    output logic [1:0]       lrg_idx,
    output logic [1:0]       sml_idx,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val
);
    typedef enum logic {LOAD, DONE} state_t;
    state_t     state;
    logic [1:0] cnt;
    logic       accept;
    logic [3:0] slot_bit;
    assign in_ready = state == LOAD;
    assign accept   = in_valid && in_ready;
    assign slot_bit = 4'b1000 >> cnt;
    // cnt wraps 3 -> 0 on the fourth accept, which is the counter clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            lrg_mask  <= 4'd0;
            sml_mask  <= 4'd0;
            lrg_idx   <= 2'd0;
            sml_idx   <= 2'd0;
            max_val   <= '0;
            min_val   <= '0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                state     <= DONE;
                out_valid <= 1'b1;
            end
            if (cnt == 2'd0) begin
                max_val  <= in_data;
                min_val  <= in_data;
                lrg_mask <= 4'b1000;
                sml_mask <= 4'b1000;
                lrg_idx  <= 2'd0;
                sml_idx  <= 2'd0;
            end else begin
                if (in_data > max_val) begin
                    max_val  <= in_data;
                    lrg_mask <= slot_bit;
                    lrg_idx  <= cnt;
                end else if (in_data == max_val) begin
                    lrg_mask <= lrg_mask | slot_bit;
                end
                if (in_data < min_val) begin
                    min_val  <= in_data;
                    sml_mask <= slot_bit;
                    sml_idx  <= cnt;
                end else if (in_data == min_val) begin
                    sml_mask <= sml_mask | slot_bit;
                end
            end
        end else if (state == DONE && out_ready) begin
            state     <= LOAD;
            out_valid <= 1'b0;
        end
    end
endmodule
